// File: rtl/alu_seq.sv
// Multi-cycle handshaked ALU: bitwise/arith ops in one cycle, shifts one bit per cycle.
// Optional iterative multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [4:0]       shamt,
  input  logic [3:0]       funct,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             resp_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_SEQ_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_t;

  state_t state, next_state;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [4:0]       cnt;
  logic [WIDTH-1:0] comb_res;
  logic             comb_err;
  logic [WIDTH-1:0] shift_next;
  logic             is_shift;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] acc, mcand, mplier, acc_next;
  assign acc_next = mplier[0] ? acc + mcand : acc;
`endif

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_DONE);
  assign is_shift   = (funct == 4'b1000) || (funct == 4'b1001) || (funct == 4'b1010);

  always_comb begin
    comb_res = '0;
    comb_err = 1'b0;
    case (funct)
      4'b0000: comb_res = operand1 + operand2;
      4'b0001: comb_res = operand1 - operand2;
      4'b0010: comb_res = operand1 & operand2;
      4'b0011: comb_res = operand1 | operand2;
      4'b0100: comb_res = operand1 ^ operand2;
      4'b0101: comb_res = ~(operand1 | operand2);
      4'b0110: comb_res = {{(WIDTH-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
      4'b0111: comb_res = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
      // Shifts only take this path when shamt is 0, so the result is operand1.
      4'b1000, 4'b1001, 4'b1010: comb_res = operand1;
`ifdef ALU_SEQ_MUL_EN
      4'b1011: comb_res = '0;
`endif
      default: comb_err = 1'b1;
    endcase
  end

  always_comb begin
    case (op_q)
      2'b00:   shift_next = {work[WIDTH-2:0], 1'b0};
      2'b01:   shift_next = {1'b0, work[WIDTH-1:1]};
      default: shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (is_shift && (shamt != 5'd0)) next_state = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          else if (funct == 4'b1011)      next_state = S_MUL;
`endif
          else                            next_state = S_DONE;
        end
      end
      S_SHIFT: if (cnt == 5'd1) next_state = S_DONE;
`ifdef ALU_SEQ_MUL_EN
      S_MUL:   if (cnt == 5'd0) next_state = S_DONE;
`endif
      S_DONE:  if (resp_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= 2'b00;
      work       <= '0;
      cnt        <= 5'd0;
      alu_result <= '0;
      resp_err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q <= funct[1:0];
            work <= operand1;
            cnt  <= shamt;
`ifdef ALU_SEQ_MUL_EN
            acc    <= '0;
            mcand  <= operand1;
            mplier <= operand2;
            if (funct == 4'b1011) cnt <= 5'd31;
`endif
            if (next_state == S_DONE) begin
              alu_result <= comb_res;
              resp_err   <= comb_err;
            end
          end
        end
        S_SHIFT: begin
          work <= shift_next;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            alu_result <= shift_next;
            resp_err   <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        // cnt runs 31..0, giving exactly 32 shift-add iterations.
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
          cnt    <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            alu_result <= acc_next;
            resp_err   <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
